segre_dcache_data_array: RTL and testbench

//  N-way set-associative D-cache data array; successor to the single-way data store.

---
 rtl/segre_dcache_data_array.sv | 183 ++++++++++++++++++
 tb/tb_segre_dcache_data_array.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/segre_dcache_data_array.sv
// N-way set-associative D-cache data array: byte/half/word load-store-evict port with a
// one-cycle registered response, plus a beat-wise line refill port driven by a small FSM.
module segre_dcache_data_array #(
    parameter int unsigned WORD_SIZE = 32,
    parameter int unsigned LANE_SIZE = 128,
    parameter int unsigned NUM_SETS  = 16,
    parameter int unsigned NUM_WAYS  = 2
) (
    input  logic                                 clk_i,
    input  logic                                 rsn_i,
    input  logic                                 req_valid_i,
    output logic                                 req_ready_o,
    input  logic [1:0]                           req_op_i,
    input  logic [$clog2(NUM_WAYS)-1:0]          req_way_i,
    input  logic [WORD_SIZE-1:0]                 req_addr_i,
    input  logic [1:0]                           req_type_i,
    input  logic [WORD_SIZE-1:0]                 req_data_i,
    output logic                                 rsp_valid_o,
    output logic [WORD_SIZE-1:0]                 rsp_data_o,
    output logic [LANE_SIZE-1:0]                 rsp_line_o,
    output logic                                 rsp_misaligned_o,
    input  logic                                 fill_start_i,
    input  logic [$clog2(NUM_WAYS)-1:0]          fill_way_i,
    input  logic [WORD_SIZE-1:0]                 fill_addr_i,
    input  logic                                 fill_beat_valid_i,
    input  logic [WORD_SIZE-1:0]                 fill_beat_i,
    output logic                                 fill_done_o
);

    localparam int unsigned BYTE_BITS  = $clog2(LANE_SIZE / 8);
    localparam int unsigned INDEX_BITS = $clog2(NUM_SETS);
    localparam int unsigned WAY_BITS   = $clog2(NUM_WAYS);
    localparam int unsigned BEATS      = LANE_SIZE / WORD_SIZE;
    localparam int unsigned CNT_BITS   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned WORD_BYTES = WORD_SIZE / 8;
    localparam int unsigned LANE_BYTES = LANE_SIZE / 8;
    localparam int unsigned WOFF_BITS  = $clog2(WORD_BYTES);

    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_EVICT = 2'b10;
    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;

    typedef enum logic [0:0] {StIdle, StFill} state_e;

    state_e                  r_state;
    logic [WAY_BITS-1:0]     r_fill_way;
    logic [INDEX_BITS-1:0]   r_fill_idx;
    logic [CNT_BITS-1:0]     r_cnt;
    logic                    r_fill_done;
    logic                    r_rsp_valid;
    logic [WORD_SIZE-1:0]    r_rsp_data;
    logic [LANE_SIZE-1:0]    r_rsp_line;
    logic                    r_rsp_mis;

    logic [LANE_SIZE-1:0]    r_mem [NUM_WAYS][NUM_SETS];

    logic [INDEX_BITS-1:0]   w_idx;
    logic [BYTE_BITS-1:0]    w_off;
    logic [BYTE_BITS+2:0]    w_shift;
    logic                    w_accept;
    logic                    w_is_load;
    logic                    w_is_evict;
    logic                    w_store;
    logic                    w_fill_wr;
    logic                    w_misaligned;
    logic [WORD_BYTES-1:0]   w_size_mask;
    logic [LANE_SIZE-1:0]    w_line;
    logic [LANE_SIZE-1:0]    w_rd_shifted;
    logic [WORD_SIZE-1:0]    w_load_data;
    logic [LANE_BYTES-1:0]   w_be;
    logic [LANE_SIZE-1:0]    w_wr_line;
    logic                    w_unused_addr;

    assign w_idx        = req_addr_i[INDEX_BITS+BYTE_BITS-1:BYTE_BITS];
    assign w_off        = req_addr_i[BYTE_BITS-1:0];
    assign w_shift      = {w_off, 3'b000};
    assign req_ready_o  = (r_state == StIdle) && !fill_start_i;
    assign w_accept     = req_valid_i && req_ready_o;
    assign w_is_evict   = (req_op_i == OP_EVICT);
    // Reserved opcode 2'b11 falls through to LOAD.
    assign w_is_load    = (req_op_i != OP_STORE) && !w_is_evict;
    assign w_store      = w_accept && (req_op_i == OP_STORE) && !w_misaligned;
    assign w_fill_wr    = (r_state == StFill) && fill_beat_valid_i;
    assign w_line       = r_mem[req_way_i][w_idx];
    assign w_rd_shifted = w_line >> w_shift;
    assign w_be         = LANE_BYTES'(w_size_mask) << w_off;
    assign w_wr_line    = LANE_SIZE'(req_data_i) << w_shift;

    // Tag bits live in the controller; they are deliberately dropped here.
    assign w_unused_addr = ^{req_addr_i[WORD_SIZE-1:INDEX_BITS+BYTE_BITS],
                             fill_addr_i[WORD_SIZE-1:INDEX_BITS+BYTE_BITS],
                             fill_addr_i[BYTE_BITS-1:0]};

    always_comb begin
        w_size_mask  = '0;
        w_misaligned = 1'b0;
        case (req_type_i)
            MEM_BYTE: begin
                w_size_mask[0] = 1'b1;
            end
            MEM_HALF: begin
                w_size_mask[1:0] = 2'b11;
                w_misaligned     = w_off[0];
            end
            default: begin
                w_size_mask  = '1;
                w_misaligned = |w_off[WOFF_BITS-1:0];
            end
        endcase
    end

    always_comb begin
        w_load_data = '0;
        for (int i = 0; i < int'(WORD_BYTES); i++) begin
            w_load_data[i*8 +: 8] = w_size_mask[i] ? w_rd_shifted[i*8 +: 8] : 8'h00;
        end
    end

    // Stores and refill beats are mutually exclusive: stores need IDLE, beats need FILL.
    always_ff @(posedge clk_i) begin
        if (w_store) begin
            for (int i = 0; i < int'(LANE_BYTES); i++) begin
                if (w_be[i]) begin
                    r_mem[req_way_i][w_idx][i*8 +: 8] <= w_wr_line[i*8 +: 8];
                end
            end
        end
        if (w_fill_wr) begin
            r_mem[r_fill_way][r_fill_idx][r_cnt*WORD_SIZE +: WORD_SIZE] <= fill_beat_i;
        end
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            r_state     <= StIdle;
            r_fill_way  <= '0;
            r_fill_idx  <= '0;
            r_cnt       <= '0;
            r_fill_done <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_line  <= '0;
            r_rsp_mis   <= 1'b0;
        end else begin
            r_fill_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (fill_start_i) begin
                        r_state    <= StFill;
                        r_fill_way <= fill_way_i;
                        r_fill_idx <= fill_addr_i[INDEX_BITS+BYTE_BITS-1:BYTE_BITS];
                        r_cnt      <= '0;
                    end
                end
                StFill: begin
                    if (fill_beat_valid_i) begin
                        if (r_cnt == CNT_BITS'(BEATS - 1)) begin
                            r_state     <= StIdle;
                            r_cnt       <= '0;
                            r_fill_done <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase

            r_rsp_valid <= w_accept;
            r_rsp_mis   <= w_accept && w_misaligned;
            r_rsp_data  <= (w_accept && w_is_load && !w_misaligned) ? w_load_data : '0;
            r_rsp_line  <= (w_accept && w_is_evict && !w_misaligned) ? w_line : '0;
        end
    end

    assign rsp_valid_o      = r_rsp_valid;
    assign rsp_data_o       = r_rsp_data;
    assign rsp_line_o       = r_rsp_line;
    assign rsp_misaligned_o = r_rsp_mis;
    assign fill_done_o      = r_fill_done;

endmodule

// File: tb/tb_segre_dcache_data_array.sv
// Directed bench for segre_dcache_data_array: expected responses are queued at issue time and
// checked by an independent monitor whenever rsp_valid_o is seen.
module tb_segre_dcache_data_array;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_EVICT = 2'b10;
    localparam logic [1:0] T_BYTE   = 2'b00;
    localparam logic [1:0] T_HALF   = 2'b01;
    localparam logic [1:0] T_WORD   = 2'b10;

    logic         clk_i = 1'b0;
    logic         rsn_i;
    logic         req_valid_i;
    logic         req_ready_o;
    logic [1:0]   req_op_i;
    logic [0:0]   req_way_i;
    logic [31:0]  req_addr_i;
    logic [1:0]   req_type_i;
    logic [31:0]  req_data_i;
    logic         rsp_valid_o;
    logic [31:0]  rsp_data_o;
    logic [127:0] rsp_line_o;
    logic         rsp_misaligned_o;
    logic         fill_start_i;
    logic [0:0]   fill_way_i;
    logic [31:0]  fill_addr_i;
    logic         fill_beat_valid_i;
    logic [31:0]  fill_beat_i;
    logic         fill_done_o;

    always #5 clk_i = ~clk_i;

    segre_dcache_data_array dut (
        .clk_i             (clk_i),
        .rsn_i             (rsn_i),
        .req_valid_i       (req_valid_i),
        .req_ready_o       (req_ready_o),
        .req_op_i          (req_op_i),
        .req_way_i         (req_way_i),
        .req_addr_i        (req_addr_i),
        .req_type_i        (req_type_i),
        .req_data_i        (req_data_i),
        .rsp_valid_o       (rsp_valid_o),
        .rsp_data_o        (rsp_data_o),
        .rsp_line_o        (rsp_line_o),
        .rsp_misaligned_o  (rsp_misaligned_o),
        .fill_start_i      (fill_start_i),
        .fill_way_i        (fill_way_i),
        .fill_addr_i       (fill_addr_i),
        .fill_beat_valid_i (fill_beat_valid_i),
        .fill_beat_i       (fill_beat_i),
        .fill_done_o       (fill_done_o)
    );

    typedef struct {
        string        name;
        logic [31:0]  data;
        logic [127:0] line;
        logic         mis;
    } exp_t;

    exp_t sb[$];
    int   n_checks    = 0;
    int   n_fail      = 0;
    int   done_pulses = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk_i) begin
        if (rsp_valid_o) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rsp_valid_o=1, expected no response");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_data"}, 128'(rsp_data_o), 128'(e.data));
                check({e.name, "_line"}, rsp_line_o, e.line);
                check({e.name, "_mis"}, 128'(rsp_misaligned_o), 128'(e.mis));
            end
        end
    end

    always @(posedge clk_i) begin
        if (fill_done_o) done_pulses++;
    end

    task automatic req(input string name, input logic [1:0] op, input logic way,
                       input logic [31:0] addr, input logic [1:0] typ, input logic [31:0] data,
                       input logic [31:0] e_data, input logic [127:0] e_line, input logic e_mis);
        exp_t e;
        req_valid_i = 1'b1;
        req_op_i    = op;
        req_way_i   = way;
        req_addr_i  = addr;
        req_type_i  = typ;
        req_data_i  = data;
        check({name, "_ready"}, 128'(req_ready_o), 128'(1));
        e.name = name;
        e.data = e_data;
        e.line = e_line;
        e.mis  = e_mis;
        sb.push_back(e);
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
    endtask

    // Gap cycles also pulse fill_start_i at the other way, which must be ignored mid-fill.
    task automatic fill(input string name, input logic way, input logic [31:0] addr,
                        input logic [31:0] b [4], input int gap);
        fill_start_i = 1'b1;
        fill_way_i   = way;
        fill_addr_i  = addr;
        @(posedge clk_i);
        #1;
        fill_start_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < gap; g++) begin
                fill_start_i = 1'b1;
                fill_way_i   = ~way;
                fill_addr_i  = 32'h0000_0070;
                check({name, "_ready_gap"}, 128'(req_ready_o), 128'(0));
                @(posedge clk_i);
                #1;
            end
            fill_start_i      = 1'b0;
            fill_way_i        = way;
            fill_addr_i       = addr;
            fill_beat_valid_i = 1'b1;
            fill_beat_i       = b[k];
            check({name, "_ready_beat"}, 128'(req_ready_o), 128'(0));
            @(posedge clk_i);
            #1;
            fill_beat_valid_i = 1'b0;
        end
        check({name, "_done_hi"}, 128'(fill_done_o), 128'(1));
        @(posedge clk_i);
        #1;
        check({name, "_done_lo"}, 128'(fill_done_o), 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] beats_a [4];
        logic [31:0] beats_b [4];
        logic [31:0] beats_c [4];
        logic [31:0] beats_d [4];
        beats_a = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
        beats_b = '{32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5};
        beats_c = '{32'hC000_0000, 32'hC000_0001, 32'hC000_0002, 32'hC000_0003};
        beats_d = '{32'h5000_0000, 32'h5000_0001, 32'h5000_0002, 32'h5000_0003};

        rsn_i = 1'b0;
        req_valid_i = 1'b0; req_op_i = '0; req_way_i = '0; req_addr_i = '0;
        req_type_i = '0; req_data_i = '0;
        fill_start_i = 1'b0; fill_way_i = '0; fill_addr_i = '0;
        fill_beat_valid_i = 1'b0; fill_beat_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_ready", 128'(req_ready_o), 128'(1));
        check("rst_rsp_valid", 128'(rsp_valid_o), 128'(0));
        check("rst_rsp_data", 128'(rsp_data_o), 128'(0));
        check("rst_rsp_line", rsp_line_o, 128'(0));
        check("rst_rsp_mis", 128'(rsp_misaligned_o), 128'(0));
        check("rst_fill_done", 128'(fill_done_o), 128'(0));
        rsn_i = 1'b1;
        @(posedge clk_i);
        #1;

        fill("fill_w1", 1'b1, 32'h30, beats_a, 0);
        req("ld_w1_38", OP_LOAD, 1'b1, 32'h38, T_WORD, 32'h0, 32'h3333_3333, '0, 1'b0);
        req("st_b_3d", OP_STORE, 1'b1, 32'h3D, T_BYTE, 32'h0000_00AB, 32'h0, '0, 1'b0);
        req("ld_w_3c", OP_LOAD, 1'b1, 32'h3C, T_WORD, 32'h0, 32'h4444_AB44, '0, 1'b0);
        req("ld_b_3d", OP_LOAD, 1'b1, 32'h3D, T_BYTE, 32'h0, 32'h0000_00AB, '0, 1'b0);
        req("ld_h_3c", OP_LOAD, 1'b1, 32'h3C, T_HALF, 32'h0, 32'h0000_AB44, '0, 1'b0);
        req("ld_h_33", OP_LOAD, 1'b1, 32'h33, T_HALF, 32'h0, 32'h0, '0, 1'b1);
        req("st_w_32", OP_STORE, 1'b1, 32'h32, T_WORD, 32'hFFFF_FFFF, 32'h0, '0, 1'b1);
        req("ld_w_30", OP_LOAD, 1'b1, 32'h30, T_WORD, 32'h0, 32'h1111_1111, '0, 1'b0);
        req("ld_w_34", OP_LOAD, 1'b1, 32'h34, T_WORD, 32'h0, 32'h2222_2222, '0, 1'b0);
        req("ld_h_3e", OP_LOAD, 1'b1, 32'h3E, T_HALF, 32'h0, 32'h0000_4444, '0, 1'b0);
        // Upper address bits differ but index/offset match.
        req("ld_alias", OP_LOAD, 1'b1, 32'hFF00_0338, T_WORD, 32'h0, 32'h3333_3333, '0, 1'b0);

        fill("fill_w0", 1'b0, 32'h30, beats_b, 1);
        req("w1_ld_38", OP_LOAD, 1'b1, 32'h38, T_WORD, 32'h0, 32'h3333_3333, '0, 1'b0);
        req("w0_ld_34", OP_LOAD, 1'b0, 32'h34, T_WORD, 32'h0, 32'hA5A5_A5A5, '0, 1'b0);
        req("evict_w1", OP_EVICT, 1'b1, 32'h30, T_WORD, 32'h0, 32'h0,
            128'h4444AB44_33333333_22222222_11111111, 1'b0);
        req("op11_ld", 2'b11, 1'b1, 32'h31, T_BYTE, 32'h0, 32'h0000_0011, '0, 1'b0);

        // Request and fill start collide: fill wins, request waits for the line to land.
        req_valid_i  = 1'b1;
        req_op_i     = OP_LOAD;
        req_way_i    = 1'b1;
        req_addr_i   = 32'h30;
        req_type_i   = T_WORD;
        fill_start_i = 1'b1;
        fill_way_i   = 1'b0;
        fill_addr_i  = 32'h40;
        #1;
        check("contend_ready", 128'(req_ready_o), 128'(0));
        @(posedge clk_i);
        #1;
        fill_start_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("contend_wait_ready", 128'(req_ready_o), 128'(0));
            fill_beat_valid_i = 1'b1;
            fill_beat_i       = beats_c[k];
            @(posedge clk_i);
            #1;
        end
        fill_beat_valid_i = 1'b0;
        check("contend_done", 128'(fill_done_o), 128'(1));
        check("contend_ready_after", 128'(req_ready_o), 128'(1));
        begin
            exp_t e;
            e.name = "contend_ld";
            e.data = 32'h1111_1111;
            e.line = '0;
            e.mis  = 1'b0;
            sb.push_back(e);
        end
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        req("w0_ld_44", OP_LOAD, 1'b0, 32'h44, T_WORD, 32'h0, 32'hC000_0001, '0, 1'b0);
        repeat (2) @(posedge clk_i);
        #1;

        // Reset after two of four beats.
        fill_start_i = 1'b1;
        fill_way_i   = 1'b1;
        fill_addr_i  = 32'h50;
        @(posedge clk_i);
        #1;
        fill_start_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            fill_beat_valid_i = 1'b1;
            fill_beat_i       = 32'hDEAD_0000 | 32'(k);
            @(posedge clk_i);
            #1;
        end
        fill_beat_valid_i = 1'b0;
        rsn_i = 1'b0;
        #1;
        check("midrst_ready", 128'(req_ready_o), 128'(1));
        check("midrst_done", 128'(fill_done_o), 128'(0));
        check("midrst_rsp_valid", 128'(rsp_valid_o), 128'(0));
        @(posedge clk_i);
        #1;
        rsn_i = 1'b1;
        for (int k = 2; k < 4; k++) begin
            fill_beat_valid_i = 1'b1;
            fill_beat_i       = 32'hDEAD_0000 | 32'(k);
            check("midrst_ready_beat", 128'(req_ready_o), 128'(1));
            @(posedge clk_i);
            #1;
        end
        fill_beat_valid_i = 1'b0;
        check("midrst_no_done", 128'(fill_done_o), 128'(0));
        req("post_rst_ld", OP_LOAD, 1'b1, 32'h3C, T_WORD, 32'h0, 32'h4444_AB44, '0, 1'b0);
        fill("refill_w1", 1'b1, 32'h50, beats_d, 0);
        req("ld_w1_54", OP_LOAD, 1'b1, 32'h54, T_WORD, 32'h0, 32'h5000_0001, '0, 1'b0);
        req("ld_w1_5c", OP_LOAD, 1'b1, 32'h5C, T_WORD, 32'h0, 32'h5000_0003, '0, 1'b0);

        repeat (3) @(posedge clk_i);
        #1;
        check("sb_drained", 128'(sb.size()), 128'(0));
        check("fill_done_count", 128'(done_pulses), 128'(4));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
